// File: rtl/stereo_sample_fifo.sv
// Circular FIFO of stereo (left+right) sample pairs with a first-word-fall-through
// valid/ready read side and a sticky overflow flag for writes dropped while full.
module stereo_sample_fifo #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [NUMBER_OF_BITS-1:0] out_left,
    output logic [NUMBER_OF_BITS-1:0] out_right,
    output logic [ADDR_W:0]           count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    localparam int                CNT_W      = ADDR_W + 1;
    localparam int                ENTRY_W    = 2 * NUMBER_OF_BITS;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [ENTRY_W-1:0] w_head;

    // Status is decoded from the stored count only, so out_valid never sees out_ready.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = in_valid & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    assign out_valid = ~w_empty;
    assign out_left  = w_empty ? '0 : w_head[ENTRY_W-1:NUMBER_OF_BITS];
    assign out_right = w_empty ? '0 : w_head[NUMBER_OF_BITS-1:0];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

    // NOTE: the storage array has no reset; its contents are masked by empty, and
    // leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {in_left, in_right};
        end
    end

    // NOTE: state registers use non-blocking assignments so every update within the
    // edge sees the pre-edge values of push/pop and the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Self-checking bench for stereo_sample_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_stereo_sample_fifo;

    localparam int NB    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [NB-1:0] in_left;
    logic [NB-1:0] in_right;
    logic          out_ready;
    logic          out_valid;
    logic [NB-1:0] out_left;
    logic [NB-1:0] out_right;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;

    stereo_sample_fifo #(.NUMBER_OF_BITS(NB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_left   (in_left),
        .in_right  (in_right),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_left  (out_left),
        .out_right (out_right),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of {left,right} pairs plus a sticky drop flag.
    logic [2*NB-1:0] model_q [$];
    bit              model_ovf;
    int              n_cmp = 0;
    int              n_mis = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [2*NB-1:0] head;
        head = (model_q.size() == 0) ? '0 : model_q[0];
        check({tag, ".valid"},    16'(out_valid), 16'(model_q.size() != 0));
        check({tag, ".count"},    16'(count),     16'(model_q.size()));
        check({tag, ".full"},     16'(full),      16'(model_q.size() == DEPTH));
        check({tag, ".empty"},    16'(empty),     16'(model_q.size() == 0));
        check({tag, ".overflow"}, 16'(overflow),  16'(model_ovf));
        check({tag, ".left"},     16'(out_left),  16'(head[2*NB-1:NB]));
        check({tag, ".right"},    16'(out_right), 16'(head[NB-1:0]));
    endtask

    // One clock cycle: drive inputs, confirm out_valid is unaffected by out_ready,
    // clock, advance the model, compare the full visible state.
    task automatic step(input string tag, input bit rst, input bit v,
                        input logic [NB-1:0] l, input logic [NB-1:0] r, input bit rdy);
        bit do_pop;
        bit do_push;
        reset     = rst;
        in_valid  = v;
        in_left   = l;
        in_right  = r;
        out_ready = rdy;
        #1;
        check({tag, ".pre_valid"}, 16'(out_valid), 16'(model_q.size() != 0));
        do_pop  = rdy && (model_q.size() > 0);
        do_push = v && ((model_q.size() < DEPTH) || do_pop);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({l, r});
            if (v && !do_push) model_ovf = 1'b1;
        end
        check_state(tag);
    endtask

    initial begin
        logic [NB-1:0] lv;
        logic [NB-1:0] rv;
        int            seen_99;
        reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; out_ready = 1'b0;
        model_ovf = 1'b0;
        @(negedge clk);

        // 1: reset asserted for two cycles in the middle of traffic
        step("rst0", 1, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) step("pre_rst", 0, 1, 8'(8'h40 + i), 8'(8'h50 + i), i[0]);
        step("rst_a", 1, 1, 8'hEE, 8'hEE, 1);
        step("rst_b", 1, 1, 8'hDD, 8'hDD, 1);
        check("rst.count_zero", 16'(count), 16'd0);
        check("rst.empty_one",  16'(empty), 16'd1);

        // 2: single pair, then one pop pulse
        step("single_push", 0, 1, 8'hA5, 8'h3C, 0);
        check("single.left",  16'(out_left),  16'h00A5);
        check("single.right", 16'(out_right), 16'h003C);
        step("single_pop", 0, 0, 8'h00, 8'h00, 1);
        check("single.empty", 16'(empty), 16'd1);

        // 3: fill, partial drain, refill across the pointer wrap, drain all
        for (int i = 0; i < 8; i++) step("fill", 0, 1, 8'(i), 8'(8'hF0 + i), 0);
        check("fill.full", 16'(full), 16'd1);
        for (int i = 0; i < 5; i++) step("drain5", 0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 5; i++) step("wrap_push", 0, 1, 8'(8 + i), 8'(8'hF8 + i), 0);
        check("wrap.head_left", 16'(out_left), 16'h0005);
        for (int i = 0; i < 8; i++) step("drain_all", 0, 0, 8'h00, 8'h00, 1);
        check("wrap.empty", 16'(empty), 16'd1);

        // 4: overflow while full; the dropped pair never reaches the output
        for (int i = 0; i < 8; i++) step("ovf_fill", 0, 1, 8'(8'h10 + i), 8'(8'h20 + i), 0);
        step("ovf_drop", 0, 1, 8'h77, 8'h77, 0);
        check("ovf.flag",  16'(overflow), 16'd1);
        check("ovf.count", 16'(count),    16'd8);
        for (int i = 0; i < 8; i++) begin
            step("ovf_drain", 0, 0, 8'h00, 8'h00, 1);
            assert (out_left !== 8'h77) else begin
                n_mis++;
                $error("FAIL ovf.dropped_seen: observed %0h expected not 77", out_left);
            end
            n_cmp++;
        end
        check("ovf.sticky", 16'(overflow), 16'd1);
        step("rst_c", 1, 0, 8'h00, 8'h00, 0);

        // 5: push and pop together while full
        for (int i = 0; i < 8; i++) step("pp_fill", 0, 1, 8'(8'h30 + i), 8'(8'h60 + i), 0);
        step("pp_both", 0, 1, 8'h99, 8'h66, 1);
        check("pp.count",    16'(count),    16'd8);
        check("pp.overflow", 16'(overflow), 16'd0);
        seen_99 = 0;
        for (int i = 1; i <= 8; i++) begin
            if (out_left === 8'h99 && seen_99 == 0) seen_99 = i;
            step("pp_drain", 0, 0, 8'h00, 8'h00, 1);
        end
        check("pp.order_of_99", 16'(seen_99), 16'd8);

        // 6: empty FIFO with in_valid and out_ready in the same cycle
        step("empty_both", 0, 1, 8'hC3, 8'h5A, 1);
        check("eb.count", 16'(count),    16'd1);
        check("eb.left",  16'(out_left), 16'h00C3);
        step("eb_pop", 0, 0, 8'h00, 8'h00, 1);

        // Random traffic: producer-heavy phase, then consumer-heavy, rare resets
        for (int i = 0; i < 600; i++) begin
            int pv;
            int pr;
            pv = (i < 300) ? 70 : 35;
            pr = (i < 300) ? 35 : 70;
            lv = 8'($urandom);
            rv = 8'($urandom);
            step("rand", ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < pv), lv, rv, ($urandom_range(0, 99) < pr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
